// File: rtl/ips_gen_if.sv
// Pixel-load / spike-stream bundle for the input spike generator.
// master = upstream controller, slave = ips_gen.
interface ips_gen_if #(
    parameter int M  = 784,
    parameter int PW = 8,
    parameter int AW = 10,
    parameter int SW = 16
);
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [PW-1:0] pix_data;
    logic          start_ips_gen;
    logic          next_ips_gen;
    logic [M-1:0]  ips_gen_out;
    logic          ips_valid;
    logic          img_ready;
    logic          pix_drop;
    logic [SW-1:0] step_count;

    modport master (
        output pix_we, pix_addr, pix_data, start_ips_gen, next_ips_gen,
        input  ips_gen_out, ips_valid, img_ready, pix_drop, step_count
    );

    modport slave (
        input  pix_we, pix_addr, pix_data, start_ips_gen, next_ips_gen,
        output ips_gen_out, ips_valid, img_ready, pix_drop, step_count
    );
endinterface

// File: rtl/ips_gen.sv
// Rate-coded input spike generator: one phase accumulator per pixel, the carry
// out of acc+pix is that pixel's spike for the step.
module ips_gen_lane #(
    parameter int PW         = 8,
    parameter int PHASE_INIT = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [PW-1:0] data_i,
    input  logic          start_i,
    input  logic          step_i,
    output logic          spike_o
);
    logic [PW-1:0] pix_q, pix_d;
    logic [PW-1:0] acc_q, acc_d;
    logic          spike_q, spike_d;
    logic [PW:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, pix_q};

    always_comb begin
        pix_d   = we_i ? data_i : pix_q;
        acc_d   = acc_q;
        spike_d = 1'b0;
        if (start_i) begin
            acc_d = PW'(PHASE_INIT);
        end else if (step_i) begin
            acc_d   = sum[PW-1:0];
            spike_d = sum[PW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q   <= '0;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
endmodule

module ips_gen #(
    parameter int M          = 784,
    parameter int PW         = 8,
    parameter int AW         = 10,
    parameter int PHASE_INIT = 128,
    parameter int SW         = 16
) (
    input logic      clk,
    input logic      rst,
    ips_gen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic          valid_q;
    logic          ready_q;
    logic          drop_q;
    logic [SW-1:0] cnt_q;
    logic          in_range;
    logic          accept;
    logic          step;
    logic [M-1:0]  spikes;

    // The image is frozen once running so a run sees constant rates.
    assign in_range = 32'(bus.pix_addr) < 32'(M);
    assign accept   = bus.pix_we && in_range && (state_q == IDLE);
    assign step     = (state_q == RUN) && bus.next_ips_gen && !bus.start_ips_gen;

    for (genvar i = 0; i < M; i++) begin : g_lane
        ips_gen_lane #(
            .PW         (PW),
            .PHASE_INIT (PHASE_INIT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we_i    (accept && (bus.pix_addr == AW'(i))),
            .data_i  (bus.pix_data),
            .start_i (bus.start_ips_gen),
            .step_i  (step),
            .spike_o (spikes[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            drop_q <= bus.pix_we && !accept;
            if (accept && (bus.pix_addr == AW'(M - 1)))
                ready_q <= 1'b1;
            if (bus.start_ips_gen) begin
                state_q <= RUN;
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else if (step) begin
                valid_q <= 1'b1;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ips_gen_out = spikes;
    assign bus.ips_valid   = valid_q;
    assign bus.img_ready   = ready_q;
    assign bus.pix_drop    = drop_q;
    assign bus.step_count  = cnt_q;
endmodule
